prog_seq_loader: RTL and testbench

Parametrised program loader and instruction sequencer for the fourbits CPU family. It captures instruction words strobed in from pins via `enable`/`instruc` into a DEPTH-entry program store. On command it streams the stored program to the core over a valid/ready handshake, optionally looping. It replaces the fixed 4-entry, single-mode program input path, sitting between the pad inputs and the control unit's fetch port.

---
 rtl/prog_seq_loader.sv | 127 ++++++++++++
 tb/tb_prog_seq_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_seq_loader.sv
// Program loader and instruction sequencer: captures pin-strobed words into a flop store,
// then streams them over valid/ready. Define PROG_SEQ_LOOP_EN to wrap instead of one-shot.
module prog_seq_loader #(
  parameter int unsigned INSTR_W = 5,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               enable,
  input  logic [INSTR_W-1:0] instruc,
  input  logic               run_req,
  input  logic               stop,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W:0]    load_count,
  output logic               full,
  output logic               overflow,
  output logic               running
);

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                mem_we;
  logic [INSTR_W-1:0]  mem [DEPTH];

  // enable_meta/enable_sync form the synchroniser; s2/s3 feed the rising-edge detector.
  logic enable_meta_q, enable_sync_q, s2_q, s3_q;
  logic wr_pulse;
  logic pc_last;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      enable_meta_q <= 1'b0;
      enable_sync_q <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
    end else begin
      enable_meta_q <= enable;
      enable_sync_q <= enable_meta_q;
      s2_q          <= enable_sync_q;
      s3_q          <= s2_q;
    end
  end

  assign wr_pulse = s2_q & ~s3_q;
  assign full     = (count_q == (ADDR_W+1)'(DEPTH));
  assign pc_last  = ({1'b0, pc_q} == (count_q - (ADDR_W+1)'(1)));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (wr_pulse) begin
          if (!full) begin
            mem_we  = 1'b1;
            count_d = count_q + (ADDR_W+1)'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        // A write landing in the same cycle counts toward the non-empty check.
        if (run_req && (count_d != '0)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StLoad;
          pc_d    = '0;
        end else if (instr_ready) begin
          if (pc_last) begin
`ifdef PROG_SEQ_LOOP_EN
            pc_d = '0;
`else
            state_d = StLoad;
            pc_d    = '0;
`endif
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = StLoad;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= StLoad;
      pc_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Program store is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[count_q[ADDR_W-1:0]] <= instruc;
    end
  end

  assign running     = (state_q == StRun);
  assign instr_valid = running;
  assign instr_out   = running ? mem[pc_q] : '0;
  assign load_count  = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_prog_seq_loader.sv
// Scoreboard bench for prog_seq_loader; expectations follow PROG_SEQ_LOOP_EN when defined.
module tb_prog_seq_loader;

  localparam int unsigned INSTR_W = 5;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned ADDR_W  = $clog2(DEPTH);

  logic               clk = 1'b0;
  logic               clear;
  logic               enable;
  logic [INSTR_W-1:0] instruc;
  logic               run_req;
  logic               stop;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               instr_ready;
  logic [ADDR_W:0]    load_count;
  logic               full;
  logic               overflow;
  logic               running;

  int n_checks = 0;
  int n_fail   = 0;
  logic [INSTR_W-1:0] exp_q[$];
  logic [INSTR_W-1:0] prog [3];

  prog_seq_loader #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .clear(clear), .enable(enable), .instruc(instruc), .run_req(run_req),
    .stop(stop), .instr_out(instr_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .load_count(load_count), .full(full),
    .overflow(overflow), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [INSTR_W-1:0] w);
    instruc = w;
    enable  = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    repeat (4) tick();
  endtask

  // Monitor: every accepted handshake must match the next expected word.
  always @(negedge clk) begin
    if (clear && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_handshake: got %b, expected no transfer", instr_out);
      end else begin
        check("stream_word", 32'(instr_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    prog[0] = 5'b00000;
    prog[1] = 5'b01101;
    prog[2] = 5'b01000;
    clear = 1'b0; enable = 1'b0; instruc = '0; run_req = 1'b0; stop = 1'b0;
    instr_ready = 1'b0;
    #2;
    check("rst_instr_valid", 32'(instr_valid), 0);
    check("rst_instr_out", 32'(instr_out), 0);
    check("rst_load_count", 32'(load_count), 0);
    check("rst_full", 32'(full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_running", 32'(running), 0);
    tick();
    tick();
    clear = 1'b1;
    tick();

    // Empty store: run_req ignored.
    instr_ready = 1'b1;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    check("empty_run_ignored", 32'(running), 0);
    tick();
    check("empty_valid_low", 32'(instr_valid), 0);
    instr_ready = 1'b0;

    // First word with edge-accurate store timing.
    instruc = prog[0];
    enable  = 1'b1;
    tick();           // edge k samples enable high
    tick();
    enable = 1'b0;
    tick();
    check("store_not_before_k3", 32'(load_count), 0);
    tick();
    check("store_at_k3", 32'(load_count), 1);
    tick();
    tick();
    strobe(prog[1]);
    strobe(prog[2]);
    check("load_count_3", 32'(load_count), 3);
    check("not_full_3", 32'(full), 0);

    // Full-rate stream.
    instr_ready = 1'b1;
`ifdef PROG_SEQ_LOOP_EN
    for (int i = 0; i < 7; i++) exp_q.push_back(prog[i % 3]);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    check("run_starts", 32'(running), 1);
    check("first_word", 32'(instr_out), 32'(prog[0]));
    repeat (3) tick();
    check("loop_wrapped", 32'(instr_out), 32'(prog[0]));
    check("loop_still_running", 32'(running), 1);
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("loop_stopped", 32'(running), 0);
`else
    for (int i = 0; i < 3; i++) exp_q.push_back(prog[i]);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    check("run_starts", 32'(running), 1);
    check("first_word", 32'(instr_out), 32'(prog[0]));
    tick();
    tick();
    check("last_word_running", 32'(running), 1);
    check("last_word", 32'(instr_out), 32'(prog[2]));
    tick();
    check("oneshot_ended", 32'(running), 0);
    check("oneshot_valid_low", 32'(instr_valid), 0);
    check("oneshot_out_zero", 32'(instr_out), 0);
`endif
    check("stream_drained", exp_q.size(), 0);
    check("count_retained", 32'(load_count), 3);

    // Backpressure on word 1, stop coinciding with final handshake.
    for (int i = 0; i < 3; i++) exp_q.push_back(prog[i]);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_hold_word", 32'(instr_out), 32'(prog[1]));
      check("bp_hold_valid", 32'(instr_valid), 1);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    check("bp_resume", 32'(instr_out), 32'(prog[2]));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    instr_ready = 1'b0;
    check("bp_stopped", 32'(running), 0);
    check("bp_drained", exp_q.size(), 0);

    // Strobe during RUN is dropped without flagging overflow.
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    strobe(5'b11111);
    check("run_strobe_count", 32'(load_count), 3);
    check("run_strobe_ovf", 32'(overflow), 0);
    check("run_strobe_pc_held", 32'(instr_out), 32'(prog[0]));

    // Asynchronous clear mid-RUN.
    @(posedge clk);
    #2;
    clear = 1'b0;
    #1;
    check("async_running", 32'(running), 0);
    check("async_valid", 32'(instr_valid), 0);
    check("async_out", 32'(instr_out), 0);
    check("async_count", 32'(load_count), 0);
    tick();
    clear = 1'b1;
    tick();
    check("post_clear_count", 32'(load_count), 0);

    // Fill to DEPTH, then one more strobe overflows.
    for (int i = 0; i < DEPTH; i++) strobe(INSTR_W'(i));
    check("fill_count", 32'(load_count), DEPTH);
    check("fill_full", 32'(full), 1);
    check("fill_no_ovf_yet", 32'(overflow), 0);
    strobe(5'b10101);
    check("ovf_count", 32'(load_count), DEPTH);
    check("ovf_full", 32'(full), 1);
    check("ovf_set", 32'(overflow), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
